// File: rtl/fifo_burst_writer_if.sv
// fifo_burst_writer_if: host, FIFO and AXI4 write-channel signals of the burst writer
interface fifo_burst_writer_if #(parameter int DATA_W = 32, parameter int ADDR_W = 32);
  logic start;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0] num_bursts;
  logic fifo_rd;
  logic [DATA_W-1:0] fifo_data;
  logic fifo_empty;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid, awready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic wlast, wvalid, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic busy, done, error;
  modport master (
    input start, base_addr, num_bursts, fifo_data, fifo_empty, awready, wready, bresp, bvalid,
    output fifo_rd, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output busy, done, error
  );
  modport slave (
    output start, base_addr, num_bursts, fifo_data, fifo_empty, awready, wready, bresp, bvalid,
    input fifo_rd, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input busy, done, error
  );
endinterface

// File: rtl/fifo_burst_writer.sv
// fifo_burst_writer: drains a FWFT FIFO into consecutive fixed-length AXI4 INCR write bursts
module fifo_burst_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int BURST_LEN = 4
) (
  input logic clk,
  input logic rst,
  fifo_burst_writer_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(BURST_LEN * DATA_W / 8);
  localparam logic [4:0] LAST = 5'(BURST_LEN - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [4:0] beat_q, beat_d;
  logic done_q, done_d, err_q, err_d;
  logic w_hs;
  assign bus.awvalid = state_q == ADDR;
  assign bus.awaddr = addr_q;
  assign bus.awlen = 8'(BURST_LEN - 1);
  assign bus.awsize = 3'($clog2(DATA_W / 8));
  assign bus.awburst = 2'b01;
  assign bus.wvalid = state_q == DATA && !bus.fifo_empty;
  assign bus.wdata = bus.fifo_data;
  assign bus.wstrb = '1;
  assign bus.wlast = bus.wvalid && beat_q == LAST;
  // Pop on the very edge the beat is accepted, so the FIFO head is always the next beat.
  assign w_hs = bus.wvalid && bus.wready;
  assign bus.fifo_rd = w_hs;
  assign bus.bready = state_q == RESP;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.error = err_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    beat_d = beat_q;
    done_d = 1'b0;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        err_d = 1'b0;
        done_d = bus.num_bursts == '0;
        if (bus.num_bursts != '0) begin
          addr_d = bus.base_addr;
          rem_d = bus.num_bursts;
          state_d = ADDR;
        end
      end
      ADDR: if (bus.awready) begin
        beat_d = '0;
        state_d = DATA;
      end
      DATA: if (w_hs) begin
        beat_d = beat_q + 5'd1;
        state_d = bus.wlast ? RESP : DATA;
      end
      RESP: if (bus.bvalid) begin
        err_d = err_q || bus.bresp != 2'b00;
        rem_d = rem_q - 16'd1;
        addr_d = addr_q + INC;
        done_d = rem_q == 16'd1;
        state_d = rem_q == 16'd1 ? IDLE : ADDR;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      beat_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      beat_q <= beat_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/fifo_burst_writer.md
# fifo_burst_writer

Burst-write controller for the AXI4 burst master. Drains a first-word-fall-through 32-bit FIFO into a sequence of fixed-length AXI4 INCR write bursts to consecutive addresses. Sequences each burst through address, data and response phases. Reports completion and any slave error to the host-side logic that fills the FIFO.

## Interface
- DATA_W, 32: AXI data width and FIFO word width.
- ADDR_W, 32: AXI address width.
- BURST_LEN, 4: beats per burst, legal range 1..16; sets awlen = BURST_LEN-1.
- clk  in  1  single clock; all logic is synchronous to its rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle request to begin a transfer; ignored while busy.
- base_addr  in  ADDR_W  first burst address, sampled on start; must be BURST_LEN*DATA_W/8 aligned.
- num_bursts  in  16  number of bursts, sampled on start.
- fifo_rd  out  1  pop strobe to FIFO.
- fifo_data  in  DATA_W  FIFO head word, valid whenever !fifo_empty.
- fifo_empty  in  1  FIFO empty flag.
- awaddr  out  ADDR_W, awlen out 8, awsize out 3, awburst out 2, awvalid out 1, awready in 1: AXI write-address channel.
- wdata out DATA_W, wstrb out DATA_W/8, wlast out 1, wvalid out 1, wready in 1: AXI write-data channel.
- bresp in 2, bvalid in 1, bready out 1: AXI write-response channel.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky; set if any bresp != 2'b00; cleared on the next accepted start.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - start && num_bursts != 0 → ADDR. Latch base_addr into the address register and num_bursts into the remaining-burst counter; clear error.
  - start && num_bursts == 0 → stay in IDLE; pulse done the next cycle; no AXI activity.
- ADDR:
  - awvalid = 1 with awaddr = current address.
  - Constant fields: awlen = BURST_LEN-1, awsize = log2(DATA_W/8), awburst = 2'b01.
  - awvalid && awready → DATA, beat counter = 0.
- DATA:
  - wvalid = !fifo_empty; wdata = fifo_data; wstrb = all ones.
  - wlast = (beat counter == BURST_LEN-1) && wvalid.
  - fifo_rd = wvalid && wready, combinational, so the pop and the beat land on the same edge.
  - Each handshake increments the beat counter.
  - The handshake carrying wlast → RESP.
  - An empty FIFO stalls the burst with wvalid low; no bubbles are inserted beyond that.
- RESP:
  - bready = 1.
  - On bvalid: if bresp != 0, set error. Decrement the remaining count and add BURST_LEN*DATA_W/8 to the address (wraps modulo 2^ADDR_W).
  - If remaining bursts → ADDR, else → IDLE and pulse done.
- A slave error does not abort the transfer; all requested bursts are issued.
- The FIFO is never popped outside DATA, and never popped when empty.

## Timing
- Reset values: awvalid, wvalid, wlast, bready, fifo_rd, busy, done, error all 0. awaddr = 0, wdata follows fifo_data, FSM = IDLE, counters = 0.
- start sampled at edge T → busy and awvalid high from T+1.
- Address handshake at edge T → wvalid can be high from T+1.
- Full FIFO and wready held high: BURST_LEN beats on consecutive cycles.
- Final B handshake at edge T → done = 1 and busy = 0 during T+1.
- Per-burst overhead with all ready signals high: 1 cycle ADDR + BURST_LEN cycles DATA + 1 cycle RESP.
- awvalid and wvalid, once high, stay high until their handshake completes. awaddr, wdata and wlast stay stable while their valid is high and ready is low.
- rst asserted in any state → next cycle all outputs are at reset values and the FSM is IDLE. In-flight AXI transactions are abandoned; the system resets the slave together with this block.
- start during busy has no effect.

## Test plan
- **Reset:** hold rst 5 cycles with random inputs → all outputs 0 and FSM IDLE; assert rst mid-DATA → awvalid, wvalid and fifo_rd drop the next cycle.
- **Single burst:** FIFO preloaded with 1,2,3,4, BURST_LEN=4, base_addr=0x1000, num_bursts=1, all ready signals high → awaddr=0x1000, awlen=3, beats 1..4 on 4 consecutive cycles with wlast on 4, done 1 cycle after bvalid, 4 fifo_rd pulses.
- **Multi-burst:** num_bursts=3, base_addr=0x2000 → awaddr 0x2000, 0x2010, 0x2020; 12 beats in FIFO order; one done pulse.
- **Backpressure and starvation:** wready toggles every cycle and the FIFO is refilled one word every 3 cycles → no duplicated or dropped words; fifo_rd only on wvalid && wready; wdata stable while stalled.
- **Error response:** bresp=2'b10 on burst 2 of 3 → error set and held; burst 3 still issued; done pulses; the next start clears error.
- **Zero bursts and start-while-busy:** num_bursts=0 → done next cycle, no awvalid; a start pulse during busy changes neither the address sequence nor the burst count.
